riscv_test_monitor: RTL

Synthesizable, parametrised self-check monitor for the RISCV_TOP core, and the next generation of our milestone-based bench checker. It holds a loadable table of (instruction-count, expected OUTPUT_PORT) pairs and compares OUTPUT_PORT each time the core's retired-instruction count NUM_INST reaches the next milestone. It also catches skipped milestones, timeouts and premature HALT, and reports a sticky verdict with failure diagnostics. It sits beside RISCV_TOP, in the bench or on an FPGA debug wrapper, and observes only NUM_INST, OUTPUT_PORT and HALT.

---
 rtl/riscv_test_monitor_if.sv | 43 ++++
 rtl/riscv_test_monitor.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_test_monitor_if.sv
// Bundle of the load, configuration, core-observation and verdict signals
// shared between the test monitor and whatever drives/observes it.
interface riscv_test_monitor_if #(
  parameter int DWIDTH = 32,
  parameter int IDX_W  = 5
);
  // table load and run control
  logic              LOAD_EN;
  logic [IDX_W-1:0]  LOAD_IDX;
  logic [DWIDTH-1:0] LOAD_NINST;
  logic [DWIDTH-1:0] LOAD_ANS;
  logic [IDX_W-1:0]  ACTIVE_CNT;
  logic              START;
  // observed core signals
  logic [DWIDTH-1:0] NUM_INST;
  logic [DWIDTH-1:0] OUTPUT_PORT;
  logic              HALT;
  // verdict and diagnostics
  logic              BUSY;
  logic              DONE;
  logic              PASS;
  logic              FAIL;
  logic [2:0]        FAIL_CODE;
  logic [IDX_W-1:0]  FAIL_IDX;
  logic [DWIDTH-1:0] FAIL_VAL;
  logic [IDX_W-1:0]  PASS_CNT;
  logic [IDX_W-1:0]  FAIL_CNT;
  logic [DWIDTH-1:0] CYCLE_CNT;

  modport master (
    output LOAD_EN, LOAD_IDX, LOAD_NINST, LOAD_ANS, ACTIVE_CNT, START,
    output NUM_INST, OUTPUT_PORT, HALT,
    input  BUSY, DONE, PASS, FAIL, FAIL_CODE, FAIL_IDX, FAIL_VAL,
    input  PASS_CNT, FAIL_CNT, CYCLE_CNT
  );

  modport slave (
    input  LOAD_EN, LOAD_IDX, LOAD_NINST, LOAD_ANS, ACTIVE_CNT, START,
    input  NUM_INST, OUTPUT_PORT, HALT,
    output BUSY, DONE, PASS, FAIL, FAIL_CODE, FAIL_IDX, FAIL_VAL,
    output PASS_CNT, FAIL_CNT, CYCLE_CNT
  );
endinterface

// File: rtl/riscv_test_monitor.sv
// Milestone self-check monitor for RISCV_TOP. Holds a table of
// (instruction count, expected OUTPUT_PORT) pairs, checks the core output
// when NUM_INST reaches each milestone, and reports a sticky verdict with
// diagnostics for mismatches, skipped milestones, timeouts and early HALT.
module riscv_test_monitor #(
  parameter int NUM_TEST     = 17,
  parameter int DWIDTH       = 32,
  parameter int IDX_W        = 5,
  parameter int TIMEOUT_CYC  = 100000,
  parameter int STOP_ON_FAIL = 1
) (
  input logic               CLK,
  input logic               RSTn,
  riscv_test_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0]  IDX_ZERO   = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]  IDX_ONE    = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]  NUM_TEST_W = IDX_W'(NUM_TEST);
  localparam logic [DWIDTH-1:0] D_ZERO     = {DWIDTH{1'b0}};
  localparam logic [DWIDTH-1:0] D_ONE      = {{(DWIDTH-1){1'b0}}, 1'b1};
  localparam logic [DWIDTH-1:0] D_ONES     = {DWIDTH{1'b1}};
  // last CYCLE_CNT value before the timeout verdict; unused when disabled
  localparam logic [DWIDTH-1:0] TO_LAST    = DWIDTH'(TIMEOUT_CYC - 1);
  localparam bit                TO_EN      = (TIMEOUT_CYC != 0);
  localparam bit                STOP_EN    = (STOP_ON_FAIL != 0);

  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_MISMATCH = 3'd1;
  localparam logic [2:0] FC_SKIPPED  = 3'd2;
  localparam logic [2:0] FC_TIMEOUT  = 3'd3;
  localparam logic [2:0] FC_INCOMPL  = 3'd4;
  localparam logic [2:0] FC_BADCFG   = 3'd5;

  state_t            state_r, state_s;
  logic [DWIDTH-1:0] ninst_r [NUM_TEST];
  logic [DWIDTH-1:0] ans_r   [NUM_TEST];

  logic [IDX_W-1:0]  ptr_r, ptr_s;
  logic [IDX_W-1:0]  active_r, active_s;
  logic [IDX_W-1:0]  pass_cnt_r, pass_cnt_s;
  logic [IDX_W-1:0]  fail_cnt_r, fail_cnt_s;
  logic [2:0]        fail_code_r, fail_code_s;
  logic [IDX_W-1:0]  fail_idx_r, fail_idx_s;
  logic [DWIDTH-1:0] fail_val_r, fail_val_s;
  logic [DWIDTH-1:0] cycle_cnt_r, cycle_cnt_s;
  logic              pass_r, pass_s;
  logic              fail_r, fail_s;
  logic              busy_r, done_r;

  logic [DWIDTH-1:0] cur_ninst_s, cur_ans_s;
  logic              entry_bad_s;
  logic [2:0]        entry_code_s;

  // Table write port: only in IDLE and only for in-range indices.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      for (int i = 0; i < NUM_TEST; i++) begin
        ninst_r[i] <= D_ZERO;
        ans_r[i]   <= D_ZERO;
      end
    end else if (state_r == ST_IDLE && bus.LOAD_EN && bus.LOAD_IDX < NUM_TEST_W) begin
      ninst_r[bus.LOAD_IDX] <= bus.LOAD_NINST;
      ans_r[bus.LOAD_IDX]   <= bus.LOAD_ANS;
    end
  end

  // Current milestone lookup, kept in range even when the pointer is past the table.
  always_comb begin
    cur_ninst_s = D_ZERO;
    cur_ans_s   = D_ZERO;
    if (ptr_r < NUM_TEST_W) begin
      cur_ninst_s = ninst_r[ptr_r];
      cur_ans_s   = ans_r[ptr_r];
    end else begin
      cur_ninst_s = D_ZERO;
      cur_ans_s   = D_ZERO;
    end
  end

  // Next-state and next-verdict logic: entry check, then HALT, stop-on-fail, timeout.
  always_comb begin
    state_s      = state_r;
    ptr_s        = ptr_r;
    active_s     = active_r;
    pass_cnt_s   = pass_cnt_r;
    fail_cnt_s   = fail_cnt_r;
    fail_code_s  = fail_code_r;
    fail_idx_s   = fail_idx_r;
    fail_val_s   = fail_val_r;
    cycle_cnt_s  = cycle_cnt_r;
    pass_s       = pass_r;
    fail_s       = fail_r;
    entry_bad_s  = 1'b0;
    entry_code_s = FC_NONE;

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (bus.START) begin
          // fresh run: every counter and diagnostic starts over
          ptr_s       = IDX_ZERO;
          active_s    = bus.ACTIVE_CNT;
          pass_cnt_s  = IDX_ZERO;
          fail_cnt_s  = IDX_ZERO;
          fail_code_s = FC_NONE;
          fail_idx_s  = IDX_ZERO;
          fail_val_s  = D_ZERO;
          cycle_cnt_s = D_ZERO;
          pass_s      = 1'b0;
          if (bus.ACTIVE_CNT > NUM_TEST_W) begin
            fail_s      = 1'b1;
            fail_code_s = FC_BADCFG;
            state_s     = ST_DONE;
          end else begin
            fail_s  = 1'b0;
            state_s = ST_RUN;
          end
        end else begin
          state_s = state_r;
        end
      end

      ST_RUN: begin
        cycle_cnt_s = (cycle_cnt_r == D_ONES) ? cycle_cnt_r : cycle_cnt_r + D_ONE;

        // at most one entry per cycle; a stalled NUM_INST cannot re-check
        if (ptr_r < active_r && bus.NUM_INST >= cur_ninst_s) begin
          if (bus.NUM_INST != cur_ninst_s) begin
            entry_bad_s  = 1'b1;
            entry_code_s = FC_SKIPPED;
          end else if (bus.OUTPUT_PORT != cur_ans_s) begin
            entry_bad_s  = 1'b1;
            entry_code_s = FC_MISMATCH;
          end else begin
            pass_cnt_s = pass_cnt_r + IDX_ONE;
          end
          ptr_s = ptr_r + IDX_ONE;
        end else begin
          ptr_s = ptr_r;
        end

        // diagnostics keep the first failure only
        if (entry_bad_s) begin
          fail_cnt_s = fail_cnt_r + IDX_ONE;
          if (fail_code_r == FC_NONE) begin
            fail_code_s = entry_code_s;
            fail_idx_s  = ptr_r;
            fail_val_s  = bus.OUTPUT_PORT;
          end else begin
            fail_code_s = fail_code_r;
          end
        end else begin
          fail_cnt_s = fail_cnt_r;
        end

        if (bus.HALT) begin
          state_s = ST_DONE;
          if (ptr_s < active_r) begin
            fail_s = 1'b1;
            if (fail_code_s == FC_NONE) begin
              fail_code_s = FC_INCOMPL;
              fail_idx_s  = ptr_s;
              fail_val_s  = bus.OUTPUT_PORT;
            end else begin
              fail_code_s = fail_code_s;
            end
          end else if (fail_cnt_s == IDX_ZERO) begin
            pass_s = 1'b1;
          end else begin
            fail_s = 1'b1;
          end
        end else if (STOP_EN && entry_bad_s) begin
          state_s = ST_DONE;
          fail_s  = 1'b1;
        end else if (TO_EN && cycle_cnt_r == TO_LAST) begin
          state_s = ST_DONE;
          fail_s  = 1'b1;
          if (fail_code_s == FC_NONE) begin
            fail_code_s = FC_TIMEOUT;
            fail_idx_s  = ptr_s;
            fail_val_s  = bus.OUTPUT_PORT;
          end else begin
            fail_code_s = fail_code_s;
          end
        end else begin
          state_s = ST_RUN;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Run bookkeeping and registered verdict outputs.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      ptr_r       <= IDX_ZERO;
      active_r    <= IDX_ZERO;
      pass_cnt_r  <= IDX_ZERO;
      fail_cnt_r  <= IDX_ZERO;
      fail_code_r <= FC_NONE;
      fail_idx_r  <= IDX_ZERO;
      fail_val_r  <= D_ZERO;
      cycle_cnt_r <= D_ZERO;
      pass_r      <= 1'b0;
      fail_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      ptr_r       <= ptr_s;
      active_r    <= active_s;
      pass_cnt_r  <= pass_cnt_s;
      fail_cnt_r  <= fail_cnt_s;
      fail_code_r <= fail_code_s;
      fail_idx_r  <= fail_idx_s;
      fail_val_r  <= fail_val_s;
      cycle_cnt_r <= cycle_cnt_s;
      pass_r      <= pass_s;
      fail_r      <= fail_s;
      busy_r      <= (state_s == ST_RUN);
      done_r      <= pass_s | fail_s;
    end
  end

  assign bus.BUSY      = busy_r;
  assign bus.DONE      = done_r;
  assign bus.PASS      = pass_r;
  assign bus.FAIL      = fail_r;
  assign bus.FAIL_CODE = fail_code_r;
  assign bus.FAIL_IDX  = fail_idx_r;
  assign bus.FAIL_VAL  = fail_val_r;
  assign bus.PASS_CNT  = pass_cnt_r;
  assign bus.FAIL_CNT  = fail_cnt_r;
  assign bus.CYCLE_CNT = cycle_cnt_r;

endmodule
